// File: rtl/fft_pkg.sv
// Shared types and sizing helpers for the FFT frame sequencer.
package fft_pkg;

    localparam int FFT_SCALE_W = 8;
    localparam int FRAME_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COMMIT,
        ST_CFG_WAIT,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE,
        ST_ERROR
    } fft_state_e;

    function automatic int cnt_width(input int frame_len);
        return (frame_len > 1) ? $clog2(frame_len) : 1;
    endfunction

endpackage

// File: rtl/fft_frame_counter.sv
// Counts accepted input beats and flags the final beat of a frame.
module fft_frame_counter
    import fft_pkg::*;
#(
    parameter int FRAME_LEN = 1024
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic beat,
    output logic last
);

    localparam int CW = cnt_width(FRAME_LEN);
    localparam logic [CW-1:0] TERM = CW'(FRAME_LEN - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clr || (beat && last)) begin
            count <= '0;
        end else if (beat) begin
            count <= count + CW'(1);
        end
    end

    assign last = (count == TERM);

endmodule

// File: rtl/fft_sequencer.sv
// Start/config/frame/drain sequencer in front of fft_config and the FFT core.
// state     | meaning
// IDLE      | waiting for a software start
// COMMIT    | one-cycle commit pulse to fft_config
// CFG_WAIT  | waiting for the config beat to be accepted (timed)
// LOAD      | passing FRAME_LEN samples to the core, tlast generated here
// DRAIN     | waiting for the core output frame to end (timed)
// DONE      | one-cycle completion pulse, frame count bump
// ERROR     | sticky error, left only by a start or an abort
module fft_sequencer
    import fft_pkg::*;
#(
    parameter int FRAME_LEN      = 1024,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   sw_start,
    input  logic                   sw_abort,
    input  logic [FFT_SCALE_W-1:0] sw_scale_sch,
    input  logic                   sw_forward,
    output logic [FFT_SCALE_W-1:0] scaleSch,
    output logic                   forward,
    output logic                   commit,
    input  logic                   cfg_tvalid,
    input  logic                   cfg_tready,
    input  logic [DATA_WIDTH-1:0]  s_tdata,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    output logic [DATA_WIDTH-1:0]  m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    input  logic                   out_tvalid,
    input  logic                   out_tready,
    input  logic                   out_tlast,
    input  logic                   event_tlast_unexpected,
    input  logic                   event_tlast_missing,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [FRAME_CNT_W-1:0] frames_done
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    fft_state_e       state, state_next;
    logic [TMO_W-1:0] tmo_cnt;
    logic             cfg_hs, out_hs, core_evt, beat, last, cnt_clr;

    always_comb begin
        state_next = state;
        cfg_hs     = cfg_tvalid && cfg_tready;
        out_hs     = out_tvalid && out_tready && out_tlast;
        core_evt   = event_tlast_unexpected || event_tlast_missing;
        beat       = (state == ST_LOAD) && s_tvalid && m_tready;
        case (state)
            ST_IDLE:     if (sw_start) state_next = ST_COMMIT;
            ST_COMMIT:   state_next = ST_CFG_WAIT;
            ST_CFG_WAIT: begin
                if (cfg_hs)              state_next = ST_LOAD;
                else if (tmo_cnt == '0)  state_next = ST_ERROR;
            end
            ST_LOAD: begin
                if (core_evt || out_hs)  state_next = ST_ERROR;
                else if (beat && last)   state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (core_evt)            state_next = ST_ERROR;
                else if (out_hs)         state_next = ST_DONE;
                else if (tmo_cnt == '0)  state_next = ST_ERROR;
            end
            ST_DONE:     state_next = ST_IDLE;
            ST_ERROR:    if (sw_start) state_next = ST_COMMIT;
            default:     state_next = ST_IDLE;
        endcase
        if (sw_abort) state_next = ST_IDLE;
        cnt_clr = sw_abort || (state_next == ST_ERROR);
    end

    // Timeout is a down-counter loaded on entry to each timed state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            tmo_cnt     <= '0;
            scaleSch    <= '0;
            forward     <= 1'b0;
            err         <= 1'b0;
            frames_done <= '0;
        end else begin
            state <= state_next;
            if (sw_abort) begin
                tmo_cnt <= '0;
            end else if (state == ST_COMMIT ||
                         (state == ST_LOAD && state_next == ST_DRAIN)) begin
                tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
            end else if ((state == ST_CFG_WAIT || state == ST_DRAIN) && tmo_cnt != '0) begin
                tmo_cnt <= tmo_cnt - TMO_W'(1);
            end
            if (state_next == ST_COMMIT && state != ST_COMMIT) begin
                scaleSch <= sw_scale_sch;
                forward  <= sw_forward;
            end
            if (state_next == ST_ERROR) begin
                err <= 1'b1;
            end else if (state_next == ST_COMMIT) begin
                err <= 1'b0;
            end
            if (state == ST_DONE) begin
                frames_done <= frames_done + FRAME_CNT_W'(1);
            end
        end
    end

    fft_frame_counter #(.FRAME_LEN(FRAME_LEN)) u_frame_counter (
        .clk    (clk),
        .resetn (resetn),
        .clr    (cnt_clr),
        .beat   (beat),
        .last   (last)
    );

    assign commit   = (state == ST_COMMIT);
    assign done     = (state == ST_DONE);
    assign busy     = !(state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
    assign s_tready = (state == ST_LOAD) && m_tready;
    assign m_tvalid = (state == ST_LOAD) && s_tvalid;
    assign m_tdata  = (state == ST_LOAD) ? s_tdata : '0;
    assign m_tlast  = (state == ST_LOAD) && last;

endmodule

// File: tb/tb_fft_sequencer.sv
// Self-checking bench for fft_sequencer: frame scoreboard plus timing rules.
module tb_fft_sequencer;
    import fft_pkg::*;

    localparam int FL  = 8;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic          clk, resetn;
    logic          sw_start, sw_abort, sw_forward;
    logic [7:0]    sw_scale_sch, scaleSch;
    logic          forward, commit, cfg_tvalid, cfg_tready;
    logic [DW-1:0] s_tdata, m_tdata;
    logic          s_tvalid, s_tready, m_tvalid, m_tready, m_tlast;
    logic          out_tvalid, out_tready, out_tlast;
    logic          event_tlast_unexpected, event_tlast_missing;
    logic          busy, done, err;
    logic [15:0]   frames_done;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         exp_frames = 0;
    logic [7:0] exp_sch;
    logic       exp_fwd;
    int         nb;

    fft_sequencer #(.FRAME_LEN(FL), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .resetn(resetn),
        .sw_start(sw_start), .sw_abort(sw_abort),
        .sw_scale_sch(sw_scale_sch), .sw_forward(sw_forward),
        .scaleSch(scaleSch), .forward(forward), .commit(commit),
        .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
        .event_tlast_unexpected(event_tlast_unexpected),
        .event_tlast_missing(event_tlast_missing),
        .busy(busy), .done(done), .err(err), .frames_done(frames_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        sw_start = 0; sw_abort = 0; sw_scale_sch = 8'h00; sw_forward = 0;
        cfg_tvalid = 0; cfg_tready = 0;
        s_tdata = '0; s_tvalid = 0; m_tready = 1;
        out_tvalid = 0; out_tready = 0; out_tlast = 0;
        event_tlast_unexpected = 0; event_tlast_missing = 0;
    endtask

    // Start from IDLE or ERROR; config beat accepted two cycles after commit.
    task automatic start_cfg(input logic [7:0] sch, input logic fwd);
        tick();
        sw_start = 1; sw_scale_sch = sch; sw_forward = fwd; m_tready = 1;
        #1;
        chk("busy_before_start", busy, 0);
        tick();
        sw_start = 0; sw_scale_sch = ~sch; sw_forward = ~fwd;
        exp_sch = sch; exp_fwd = fwd;
        #1;
        chk("commit_on", commit, 1);
        chk("err_cleared", err, 0);
        chk("sch_latched", scaleSch, exp_sch);
        chk("fwd_latched", forward, exp_fwd);
        chk("busy_commit", busy, 1);
        tick();
        #1;
        chk("commit_off", commit, 0);
        chk("s_tready_cfg", s_tready, 0);
        tick();
        cfg_tvalid = 1; cfg_tready = 1;
        #1;
        tick();
        cfg_tvalid = 0; cfg_tready = 0;
    endtask

    // Feeds one frame; returns early after the evt_at-th beat or rst_at-th beat.
    task automatic feed(input bit stall, input int start_at, input int evt_at,
                        input int rst_at, output int beats);
        logic [DW-1:0] q[$];
        for (int i = 0; i < FL; i++) q.push_back($urandom);
        beats = 0;
        for (int cyc = 0; cyc < 20 * FL && beats < FL; cyc++) begin
            if (cyc > 0) tick();
            sw_start = 0;
            event_tlast_missing = 0;
            m_tready = stall ? ((cyc % 2) == 0) : 1'b1;
            s_tvalid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_tdata  = q[beats];
            if (beats == start_at) begin
                sw_start = 1; sw_scale_sch = 8'h11; sw_forward = ~exp_fwd;
            end
            if (beats == evt_at - 1) event_tlast_missing = 1;
            #1;
            chk("s_tready_pass", s_tready, m_tready);
            chk("m_tvalid_pass", m_tvalid, s_tvalid);
            chk("sch_hold", scaleSch, exp_sch);
            chk("fwd_hold", forward, exp_fwd);
            if (s_tvalid && m_tready) begin
                chk("m_tdata", m_tdata, q[beats]);
                chk("m_tlast", m_tlast, beats == FL - 1);
                beats++;
                if (beats == evt_at) return;
                if (beats == rst_at) begin
                    #2 resetn = 0;
                    #1;
                    return;
                end
            end
        end
    endtask

    task automatic drain_done();
        int w;
        tick();
        sw_start = 0; event_tlast_missing = 0;
        #1;
        chk("m_tvalid_drain", m_tvalid, 0);
        chk("s_tready_drain", s_tready, 0);
        chk("m_tlast_drain", m_tlast, 0);
        chk("busy_drain", busy, 1);
        w = $urandom_range(0, 4);
        for (int i = 0; i < w; i++) tick();
        tick();
        out_tvalid = 1; out_tready = 1; out_tlast = 1;
        #1;
        tick();
        out_tvalid = 0; out_tready = 0; out_tlast = 0;
        #1;
        chk("done_pulse", done, 1);
        chk("busy_done", busy, 0);
        chk("frames_before", frames_done, exp_frames);
        exp_frames = (exp_frames + 1) % 65536;
        tick();
        #1;
        chk("done_single", done, 0);
        chk("frames_after", frames_done, exp_frames);
        chk("busy_idle", busy, 0);
        chk("sch_final", scaleSch, exp_sch);
    endtask

    task automatic normal_frame(input logic [7:0] sch, input logic fwd,
                                input bit stall, input int start_at);
        start_cfg(sch, fwd);
        feed(stall, start_at, -1, -1, nb);
        chk("beat_count", nb, FL);
        drain_done();
    endtask

    initial begin
        int n;
        idle_inputs();
        resetn = 0;
        tick();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_commit", commit, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_frames", frames_done, 0);
        chk("rst_sch", scaleSch, 0);
        chk("rst_fwd", forward, 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        tick();
        resetn = 1;

        normal_frame(8'hA5, 1'b1, 1'b0, -1);
        normal_frame(8'hA5, 1'b1, 1'b1, -1);
        normal_frame(8'hA5, 1'b1, 1'b0, 4);
        for (int r = 0; r < 3; r++)
            normal_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1, -1);

        // Config never accepted: error after TMO cycles in CFG_WAIT.
        tick();
        sw_start = 1; sw_scale_sch = 8'h3C; sw_forward = 0;
        tick();
        sw_start = 0;
        #1;
        chk("tmo_commit", commit, 1);
        n = 0;
        while (n < 100) begin
            tick();
            #1;
            n++;
            if (err) break;
        end
        chk("tmo_cycles", n - 1, TMO);
        chk("tmo_err", err, 1);
        chk("tmo_s_tready", s_tready, 0);
        chk("tmo_busy", busy, 0);
        normal_frame(8'h5A, 1'b0, 1'b0, -1);

        // Core error event on beat 5, then abort.
        start_cfg(8'h77, 1'b1);
        feed(1'b0, -1, 5, -1, nb);
        chk("evt_beats", nb, 5);
        tick();
        event_tlast_missing = 0;
        #1;
        chk("evt_err", err, 1);
        chk("evt_state", dut.state, ST_ERROR);
        chk("evt_s_tready", s_tready, 0);
        chk("evt_frames", frames_done, exp_frames);
        tick();
        sw_abort = 1;
        tick();
        sw_abort = 0;
        #1;
        chk("abort_state", dut.state, ST_IDLE);
        chk("abort_err", err, 1);
        normal_frame(8'hC3, 1'b0, 1'b0, -1);

        // Asynchronous reset mid-frame.
        start_cfg(8'h99, 1'b1);
        feed(1'b0, -1, -1, 3, nb);
        chk("arst_busy", busy, 0);
        chk("arst_err", err, 0);
        chk("arst_frames", frames_done, 0);
        chk("arst_sch", scaleSch, 0);
        chk("arst_fwd", forward, 0);
        chk("arst_s_tready", s_tready, 0);
        chk("arst_m_tvalid", m_tvalid, 0);
        chk("arst_m_tlast", m_tlast, 0);
        exp_frames = 0;
        tick();
        idle_inputs();
        resetn = 1;
        normal_frame(8'h42, 1'b1, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_sequencer.md
Name: fft_sequencer

Overview:
Control stage directly upstream of fft_config and the FFT core data input. It latches a software start request and its parameters, then pulses commit to fft_config and waits for that config beat to be accepted. It then passes one FRAME_LEN-sample frame from the sample source to the core, generating tlast itself, and waits for the core's output frame to finish. It reports busy, done and error status and a completed-frame count.

Parameters:
FRAME_LEN, 1024, samples per FFT frame; power of two, minimum 4.
DATA_WIDTH, 32, sample bus width.
TIMEOUT_CYCLES, 65535, maximum cycles spent in CFG_WAIT or DRAIN before the error path is taken.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
sw_start  in  1  one-cycle start request
sw_abort  in  1  one-cycle abort request
sw_scale_sch  in  8  scaling schedule for the next frame
sw_forward  in  1  1 selects forward FFT, 0 selects inverse
scaleSch  out  8  to fft_config
forward  out  1  to fft_config
commit  out  1  to fft_config, one-cycle pulse
cfg_tvalid  in  1  monitor of the config channel from fft_config
cfg_tready  in  1  monitor of the config channel from the core
s_tdata  in  DATA_WIDTH  source samples
s_tvalid  in  1  source sample valid
s_tready  out  1  source sample ready
m_tdata  out  DATA_WIDTH  samples to the core
m_tvalid  out  1  to the core
m_tready  in  1  from the core
m_tlast  out  1  frame end to the core
out_tvalid  in  1  monitor of the core output stream
out_tready  in  1  monitor of the core output stream
out_tlast  in  1  monitor of the core output stream
event_tlast_unexpected  in  1  core error event
event_tlast_missing  in  1  core error event
busy  out  1  1 whenever state is not IDLE, DONE or ERROR
done  out  1  one-cycle pulse at frame completion
err  out  1  sticky error flag
frames_done  out  16  count of completed frames

Behaviour:
- Reset values: state=IDLE, scaleSch=0, forward=0, commit=0, done=0, err=0, frames_done=0, sample counter=0, timeout counter=0, busy=0.
- States: IDLE, COMMIT, CFG_WAIT, LOAD, DRAIN, DONE, ERROR.
- Transitions:
  - IDLE: sw_start=1 latches sw_scale_sch into scaleSch and sw_forward into forward, then goes to COMMIT. scaleSch and forward then hold until the next accepted start.
  - COMMIT: commit=1 for exactly this one cycle; always goes to CFG_WAIT. The timeout counter is cleared on entry.
  - CFG_WAIT: cfg_tvalid and cfg_tready both 1 goes to LOAD. Timeout counter reaching TIMEOUT_CYCLES goes to ERROR.
  - LOAD: combinational passthrough. m_tdata=s_tdata, m_tvalid=s_tvalid, s_tready=m_tready. A beat is s_tvalid and m_tready both 1; each beat increments the sample counter. m_tlast=1 when the counter equals FRAME_LEN-1. The beat carrying m_tlast clears the counter and goes to DRAIN.
  - DRAIN: out_tvalid, out_tready and out_tlast all 1 goes to DONE. Timeout counter reaching TIMEOUT_CYCLES goes to ERROR. The timeout counter is cleared on entry.
  - DONE: done=1 for one cycle, frames_done increments (wraps 0xFFFF to 0), then goes to IDLE.
  - ERROR: err=1, held until a start is accepted. sw_start=1 clears err, latches parameters and goes to COMMIT.
- Outside LOAD: s_tready=0, m_tvalid=0, m_tlast=0.
- Error events: event_tlast_unexpected or event_tlast_missing in LOAD or DRAIN goes to ERROR. An out_tlast handshake during LOAD also goes to ERROR. The sample counter is cleared on ERROR.
- sw_abort: highest priority in any state. Goes to IDLE, clears the counters, leaves err unchanged. sw_abort and sw_start in the same cycle: abort wins and the start is dropped.
- sw_start while in COMMIT, CFG_WAIT, LOAD, DRAIN or DONE is ignored; parameters are not relatched.
- A config handshake seen in CFG_WAIT on the same cycle the timeout expires counts as success.
- Reset asserted mid-frame returns every register to its reset value immediately.

Decomposition:
- Shared package fft_pkg holds: the state enum, FFT_SCALE_W=8, FRAME_CNT_W=16, and a cnt_width(FRAME_LEN) helper function.
- One natural sub-module, fft_frame_counter: the beat counter with terminal-count flag that produces m_tlast. The state machine stays in fft_sequencer.

Test Plan:
- FRAME_LEN=8. Pulse sw_start with sw_scale_sch=0xA5 and sw_forward=1; the config model accepts the beat 2 cycles after commit. Feed 8 samples with no stalls, then pulse out_tlast. Required: commit high for 1 cycle; scaleSch=0xA5 and forward=1 stable throughout; m_tlast only on beat 8; done pulses once; frames_done=1; busy falls.
- Same frame with m_tready toggled every other cycle. Required: exactly 8 beats; data order preserved; m_tlast only on beat 8; no beat lost or duplicated.
- sw_start with sw_scale_sch=0x11 pulsed during LOAD of the frame started with 0xA5. Required: ignored; scaleSch stays 0xA5; the frame completes normally.
- TIMEOUT_CYCLES=16 and cfg_tready held at 0. Required: ERROR entered on cycle 16 of CFG_WAIT; err=1; s_tready=0. A later sw_start clears err and commit pulses again.
- event_tlast_missing pulsed at beat 5 of LOAD. Required: ERROR, err=1, frames_done unchanged. Then sw_abort: state IDLE, err still 1.
- resetn driven low at beat 3 of LOAD. Required: all outputs at reset values immediately, without waiting for a clock edge. After release, a normal frame still completes.
